// File: rtl/a2d_intf_if.sv
// Request/result and SPI pin bundle for a2d_intf.
// master = the SPI-master block itself; slave = sequencer plus A2D side.
interface a2d_intf_if;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;

   modport master (
      input  strt_cnv, chnnl, MISO,
      output cnv_cmplt, res, SS_n, SCLK, MOSI
   );

   modport slave (
      output strt_cnv, chnnl, MISO,
      input  cnv_cmplt, res, SS_n, SCLK, MOSI
   );
endinterface

// File: rtl/a2d_intf.sv
// SPI master for an ADC128S-style A2D: strt_cnv -> two 16-bit frames (SCLK = clk/32) -> res/cnv_cmplt 1044 clks later.
// strt_cnv while busy is ignored; define A2D_RES_INV_EN to report the inverted 12-bit reading.
module a2d_intf (
   input  logic       clk,
   input  logic       rst_n,
   a2d_intf_if.master bus
);

   typedef enum logic [1:0] {IDLE, FRM1, GAP, FRM2} state_t;

   localparam logic [4:0] DIV_LOAD = 5'b10111;
   localparam logic [4:0] DIV_RISE = 5'b01111;
   localparam logic [4:0] DIV_FALL = 5'b11111;

   state_t      r_state;
   state_t      w_nxt_state;
   logic [4:0]  r_div;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_shft;
   logic        r_sample;
   logic [2:0]  r_chnnl;
   logic        r_ss_n;
   logic        r_sclk;
   logic        r_cnv_cmplt;
   logic [11:0] r_res;

   logic        w_in_frm;
   logic        w_nxt_frm;
   logic        w_rise;
   logic        w_fall;
   logic        w_frm_done;
   logic        w_accept;
   logic        w_load_frm;
   logic        w_set_cmplt;
   logic [4:0]  w_div_nxt;
   logic [15:0] w_cmd;
   logic [11:0] w_rx;
   logic [11:0] w_res;

   assign w_in_frm  = (r_state == FRM1) || (r_state == FRM2);
   assign w_nxt_frm = (w_nxt_state == FRM1) || (w_nxt_state == FRM2);
   assign w_rise    = w_in_frm && (r_div == DIV_RISE);
   // A fall only shifts once a bit has been sampled, so the front-porch 11111 is skipped.
   assign w_fall     = w_in_frm && (r_div == DIV_FALL) && (r_bit_cnt != 5'd0);
   assign w_frm_done = w_fall && (r_bit_cnt == 5'd16);

   assign w_cmd     = w_accept ? {2'b00, bus.chnnl, 11'h000} : {2'b00, r_chnnl, 11'h000};
   assign w_div_nxt = w_load_frm ? DIV_LOAD : (w_in_frm ? r_div + 5'd1 : r_div);
   assign w_rx      = {r_shft[10:0], r_sample};

`ifdef A2D_RES_INV_EN
   assign w_res = ~w_rx;
`else
   assign w_res = w_rx;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_accept    = 1'b0;
      w_load_frm  = 1'b0;
      w_set_cmplt = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.strt_cnv) begin
               w_nxt_state = FRM1;
               w_accept    = 1'b1;
               w_load_frm  = 1'b1;
            end
         end
         FRM1: begin
            if (w_frm_done) begin
               w_nxt_state = GAP;
            end
         end
         GAP: begin
            w_nxt_state = FRM2;
            w_load_frm  = 1'b1;
         end
         FRM2: begin
            if (w_frm_done) begin
               w_nxt_state = IDLE;
               w_set_cmplt = 1'b1;
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // SCLK and SS_n come straight from flops so the pins never glitch on state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div       <= 5'd0;
         r_bit_cnt   <= 5'd0;
         r_shft      <= 16'h0000;
         r_sample    <= 1'b0;
         r_chnnl     <= 3'd0;
         r_ss_n      <= 1'b1;
         r_sclk      <= 1'b1;
         r_cnv_cmplt <= 1'b0;
         r_res       <= 12'h000;
      end else begin
         r_div  <= w_div_nxt;
         r_ss_n <= ~w_nxt_frm;
         r_sclk <= w_nxt_frm ? w_div_nxt[4] : 1'b1;
         if (w_accept) begin
            r_chnnl     <= bus.chnnl;
            r_cnv_cmplt <= 1'b0;
         end
         if (w_load_frm) begin
            r_shft    <= w_cmd;
            r_bit_cnt <= 5'd0;
         end else begin
            if (w_rise) begin
               r_sample  <= bus.MISO;
               r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (w_fall) begin
               r_shft <= {r_shft[14:0], r_sample};
            end
         end
         if (w_set_cmplt) begin
            r_cnv_cmplt <= 1'b1;
            r_res       <= w_res;
         end
      end
   end

   assign bus.SS_n      = r_ss_n;
   assign bus.SCLK      = r_sclk;
   assign bus.MOSI      = r_shft[15];
   assign bus.cnv_cmplt = r_cnv_cmplt;
   assign bus.res       = r_res;

endmodule
